// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer
//
// Receive-side deserializer for the USB RX path. It hunts the serial bit
// stream for the SYNC pattern, then assembles LSB-first bytes and keeps a
// rolling history window of recent bytes for the RX control FSM.
//
// Optional feature: define USB_RX_BITSTUFF_EN to enable bit-stuff removal.
// With it, the stuff bit that follows six consecutive data 1s is dropped.
// If that stuff bit is a 1 instead of a 0, a framing error is reported.
//
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   shift_enable in   d_orig is valid this cycle
//   d_orig       in   decoded serial bit
//   eop          in   end-of-packet pulse
//   clear        in   synchronous abort back to IDLE, no strobes
//   rx_byte      out  last completed byte
//   byte_ready   out  strobe: rx_byte/window/byte_count updated
//   sync_found   out  strobe: SYNC matched
//   pkt_done     out  strobe: EOP on a byte boundary
//   byte_err     out  strobe: framing or stuff error
//   byte_count   out  bytes since SYNC, saturating at 255
//   window       out  byte history, newest byte in the low DATA_BITS bits
module usb_rx_deserializer #(
    parameter int unsigned          DATA_BITS    = 8,
    parameter int unsigned          HISTORY      = 3,
    parameter logic [DATA_BITS-1:0] SYNC_PATTERN = DATA_BITS'(8'h80)
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           shift_enable,
    input  logic                           d_orig,
    input  logic                           eop,
    input  logic                           clear,
    output logic [DATA_BITS-1:0]           rx_byte,
    output logic                           byte_ready,
    output logic                           sync_found,
    output logic                           pkt_done,
    output logic                           byte_err,
    output logic [7:0]                     byte_count,
    output logic [DATA_BITS*HISTORY-1:0]   window
);

    localparam int unsigned    BCW      = $clog2(DATA_BITS);
    localparam int unsigned    WW       = DATA_BITS * HISTORY;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e                 state_q,     state_d;
    logic [DATA_BITS-1:0]   shiftReg_q,  shiftReg_d;
    logic [BCW-1:0]         bitCnt_q,    bitCnt_d;
    logic [DATA_BITS-1:0]   rxByte_q,    rxByte_d;
    logic [WW-1:0]          window_q,    window_d;
    logic [7:0]             byteCount_q, byteCount_d;
    logic                   byteReady_q, byteReady_d;
    logic                   syncFound_q, syncFound_d;
    logic                   pktDone_q,   pktDone_d;
    logic                   byteErr_q,   byteErr_d;
`ifdef USB_RX_BITSTUFF_EN
    logic [2:0]             onesCnt_q,   onesCnt_d;
`endif

    // Value the shift register takes if the current bit is accepted:
    // new bit enters at the MSB so the first received bit ends up at bit 0.
    logic [DATA_BITS-1:0]   shifted;
    assign shifted = {d_orig, shiftReg_q[DATA_BITS-1:1]};

    // Next-state logic. Priority is clear, then eop, then shift_enable;
    // a bit that arrives together with eop is dropped.
    always_comb begin
        state_d     = state_q;
        shiftReg_d  = shiftReg_q;
        bitCnt_d    = bitCnt_q;
        rxByte_d    = rxByte_q;
        window_d    = window_q;
        byteCount_d = byteCount_q;
        byteReady_d = 1'b0;
        syncFound_d = 1'b0;
        pktDone_d   = 1'b0;
        byteErr_d   = 1'b0;
`ifdef USB_RX_BITSTUFF_EN
        onesCnt_d   = onesCnt_q;
`endif

        if (clear) begin
            state_d  = IDLE;
            bitCnt_d = '0;
`ifdef USB_RX_BITSTUFF_EN
            onesCnt_d = 3'd0;
`endif
        end else if (eop) begin
            if (state_q == ACTIVE) begin
                if (bitCnt_q == '0) begin
                    pktDone_d = 1'b1;
                end else begin
                    byteErr_d = 1'b1;
                end
            end
            state_d  = IDLE;
            bitCnt_d = '0;
`ifdef USB_RX_BITSTUFF_EN
            onesCnt_d = 3'd0;
`endif
        end else if (shift_enable) begin
            if (state_q == IDLE) begin
                shiftReg_d = shifted;
                if (shifted == SYNC_PATTERN) begin
                    syncFound_d = 1'b1;
                    state_d     = ACTIVE;
                    bitCnt_d    = '0;
                    byteCount_d = 8'd0;
                    window_d    = '0;
`ifdef USB_RX_BITSTUFF_EN
                    onesCnt_d   = 3'd0;
`endif
                end
            end else begin
`ifdef USB_RX_BITSTUFF_EN
                // After six data 1s the next bit is a stuff bit: a 0 is
                // dropped without touching the byte, a 1 is a violation.
                if (onesCnt_q == 3'd6) begin
                    onesCnt_d = 3'd0;
                    if (d_orig) begin
                        byteErr_d = 1'b1;
                        state_d   = IDLE;
                        bitCnt_d  = '0;
                    end
                end else begin
                    onesCnt_d = d_orig ? onesCnt_q + 3'd1 : 3'd0;
`endif
                    shiftReg_d = shifted;
                    if (bitCnt_q == LAST_BIT) begin
                        rxByte_d    = shifted;
                        window_d    = (window_q << DATA_BITS) | WW'(shifted);
                        byteCount_d = (byteCount_q == 8'hFF) ? 8'hFF
                                                             : byteCount_q + 8'd1;
                        byteReady_d = 1'b1;
                        bitCnt_d    = '0;
                    end else begin
                        bitCnt_d = bitCnt_q + BCW'(1);
                    end
`ifdef USB_RX_BITSTUFF_EN
                end
`endif
            end
        end
    end

    // State and registered outputs; reset is asynchronous so a reset in the
    // middle of a packet drops back to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            bitCnt_q    <= '0;
            rxByte_q    <= '0;
            window_q    <= '0;
            byteCount_q <= 8'd0;
            byteReady_q <= 1'b0;
            syncFound_q <= 1'b0;
            pktDone_q   <= 1'b0;
            byteErr_q   <= 1'b0;
`ifdef USB_RX_BITSTUFF_EN
            onesCnt_q   <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            shiftReg_q  <= shiftReg_d;
            bitCnt_q    <= bitCnt_d;
            rxByte_q    <= rxByte_d;
            window_q    <= window_d;
            byteCount_q <= byteCount_d;
            byteReady_q <= byteReady_d;
            syncFound_q <= syncFound_d;
            pktDone_q   <= pktDone_d;
            byteErr_q   <= byteErr_d;
`ifdef USB_RX_BITSTUFF_EN
            onesCnt_q   <= onesCnt_d;
`endif
        end
    end

    assign rx_byte    = rxByte_q;
    assign byte_ready = byteReady_q;
    assign sync_found = syncFound_q;
    assign pkt_done   = pktDone_q;
    assign byte_err   = byteErr_q;
    assign byte_count = byteCount_q;
    assign window     = window_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// tb_usb_rx_deserializer
//
// Scoreboard bench for usb_rx_deserializer (default parameters). Stimulus
// tasks push the strobe they expect into a queue; a monitor pops and compares
// every time the DUT raises a strobe. Also exercises the bit-stuff path when
// USB_RX_BITSTUFF_EN is defined.
module tb_usb_rx_deserializer;

    localparam logic [3:0] EV_SYNC = 4'b0001;
    localparam logic [3:0] EV_BYTE = 4'b0010;
    localparam logic [3:0] EV_PKT  = 4'b0100;
    localparam logic [3:0] EV_ERR  = 4'b1000;

    logic        clk;
    logic        n_rst;
    logic        shift_enable;
    logic        d_orig;
    logic        eop;
    logic        clear;
    logic [7:0]  rx_byte;
    logic        byte_ready;
    logic        sync_found;
    logic        pkt_done;
    logic        byte_err;
    logic [7:0]  byte_count;
    logic [23:0] window;

    typedef struct {
        logic [3:0]  kind;
        logic [7:0]  rxb;
        logic [23:0] win;
        logic [7:0]  cnt;
        bit          chkRx;
        bit          chkWin;
    } ev_t;

    ev_t expQ[$];
    int  total = 0;
    int  bad   = 0;
    int  tbOnes = 0;

    usb_rx_deserializer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .d_orig       (d_orig),
        .eop          (eop),
        .clear        (clear),
        .rx_byte      (rx_byte),
        .byte_ready   (byte_ready),
        .sync_found   (sync_found),
        .pkt_done     (pkt_done),
        .byte_err     (byte_err),
        .byte_count   (byte_count),
        .window       (window)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait somewhere never completes
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushEv(input logic [3:0] kind, input logic [7:0] rxb, input logic [23:0] win,
                          input logic [7:0] cnt, input bit chkRx, input bit chkWin);
        ev_t e;
        e.kind = kind; e.rxb = rxb; e.win = win; e.cnt = cnt; e.chkRx = chkRx; e.chkWin = chkWin;
        expQ.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (n_rst && (sync_found || byte_ready || pkt_done || byte_err)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected strobe", {28'd0, byte_err, pkt_done, byte_ready, sync_found}, 32'd0);
            end else begin
                ev_t e;
                e = expQ.pop_front();
                checkOutput("strobe kind", {28'd0, byte_err, pkt_done, byte_ready, sync_found}, {28'd0, e.kind});
                checkOutput("byte_count", {24'd0, byte_count}, {24'd0, e.cnt});
                if (e.chkRx)  checkOutput("rx_byte", {24'd0, rx_byte}, {24'd0, e.rxb});
                if (e.chkWin) checkOutput("window", {8'd0, window}, {8'd0, e.win});
            end
        end
    end

    task automatic applyStimulus(input logic se, input logic d, input logic ep, input logic cl);
        @(posedge clk);
        #1;
        shift_enable = se;
        d_orig       = d;
        eop          = ep;
        clear        = cl;
    endtask

    task automatic sendBit(input logic b);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
    endtask

    // Data bit; inserts the stuff bit after six 1s when stuffing is enabled
    task automatic sendDataBit(input logic b);
        sendBit(b);
`ifdef USB_RX_BITSTUFF_EN
        tbOnes = b ? tbOnes + 1 : 0;
        if (tbOnes == 6) begin
            sendBit(1'b0);
            tbOnes = 0;
        end
`endif
    endtask

    task automatic sendByte(input logic [7:0] b, input logic [23:0] win, input logic [7:0] cnt);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) pushEv(EV_BYTE, b, win, cnt, 1'b1, 1'b1);
            sendDataBit(b[i]);
        end
    endtask

    // 0x80 LSB-first: seven 0s then a 1
    task automatic sendSync();
        tbOnes = 0;
        for (int i = 0; i < 7; i++) sendBit(1'b0);
        pushEv(EV_SYNC, 8'h00, 24'h0, 8'd0, 1'b0, 1'b1);
        sendBit(1'b1);
    endtask

    task automatic sendEop(input logic [3:0] kind, input logic [7:0] rxb, input logic [7:0] cnt,
                           input bit expectStrobe);
        if (expectStrobe) pushEv(kind, rxb, 24'h0, cnt, 1'b1, 1'b0);
        tbOnes = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Idle until every expected strobe was seen, bounded
    task automatic drain();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        checkOutput("queue drained", expQ.size(), 32'd0);
        expQ.delete();
    endtask

    initial begin
        logic [23:0] win;
        logic [7:0]  b;
        logic [7:0]  cnt;

        n_rst = 1'b0; shift_enable = 1'b0; d_orig = 1'b0; eop = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rx_byte", {24'd0, rx_byte}, 32'd0);
        checkOutput("reset window", {8'd0, window}, 32'd0);
        checkOutput("reset byte_count", {24'd0, byte_count}, 32'd0);
        checkOutput("reset strobes", {28'd0, byte_err, pkt_done, byte_ready, sync_found}, 32'd0);
        n_rst = 1'b1;

        $display("[TB] sync detect and three-byte packet");
        sendSync();
        sendByte(8'hC3, 24'h0000C3, 8'd1);
        sendByte(8'hA5, 24'h00C3A5, 8'd2);
        sendByte(8'h3C, 24'hC3A53C, 8'd3);
        sendEop(EV_PKT, 8'h3C, 8'd3, 1'b1);
        drain();
        checkOutput("window after packet", {8'd0, window}, 32'h00C3A53C);

        $display("[TB] eop mid-byte");
        sendSync();
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        sendEop(EV_ERR, 8'h3C, 8'd0, 1'b1);
        drain();
        checkOutput("rx_byte held after error", {24'd0, rx_byte}, 32'h3C);
        sendEop(EV_PKT, 8'h00, 8'd0, 1'b0);
        drain();

        $display("[TB] clear with shift_enable");
        sendSync();
        sendByte(8'h11, 24'h000011, 8'd1);
        sendByte(8'h22, 24'h001122, 8'd2);
        tbOnes = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        drain();
        checkOutput("byte_count held after clear", {24'd0, byte_count}, 32'd2);
        checkOutput("window held after clear", {8'd0, window}, 32'h00001122);
        sendSync();
        sendEop(EV_PKT, 8'h22, 8'd0, 1'b1);
        drain();

        $display("[TB] all-ones byte");
        sendSync();
        sendByte(8'hFF, 24'h0000FF, 8'd1);
        sendEop(EV_PKT, 8'hFF, 8'd1, 1'b1);
        drain();
`ifdef USB_RX_BITSTUFF_EN
        $display("[TB] stuff violation");
        sendSync();
        for (int i = 0; i < 6; i++) sendBit(1'b1);
        pushEv(EV_ERR, 8'hFF, 24'h0, 8'd0, 1'b1, 1'b0);
        sendBit(1'b1);
        drain();
        sendEop(EV_PKT, 8'h00, 8'd0, 1'b0);
        drain();
`endif

        $display("[TB] reset mid-packet");
        sendSync();
        sendByte(8'h5A, 24'h00005A, 8'd1);
        sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
        drain();
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("mid reset rx_byte", {24'd0, rx_byte}, 32'd0);
        checkOutput("mid reset byte_count", {24'd0, byte_count}, 32'd0);
        checkOutput("mid reset window", {8'd0, window}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        drain();
        sendSync();
        sendEop(EV_PKT, 8'h00, 8'd0, 1'b1);
        drain();

        $display("[TB] 300 back-to-back bytes");
        sendSync();
        win = 24'h0;
        for (int i = 0; i < 300; i++) begin
            b   = 8'(i);
            win = {win[15:0], b};
            cnt = (i < 255) ? 8'(i + 1) : 8'd255;
            sendByte(b, win, cnt);
        end
        sendEop(EV_PKT, 8'h2B, 8'd255, 1'b1);
        drain();
        checkOutput("saturated byte_count", {24'd0, byte_count}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
